// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser
// Purpose  : Byte-level command-frame sequencer placed behind a UART receiver.
//            Frame format: HDR0 HDR1 CMD LEN PAYLOAD[LEN] CSUM, where
//            CSUM = (CMD + LEN + sum of payload bytes) mod 256.
//            Payload bytes are streamed out as they arrive. Each frame gets at
//            most one verdict (frame_ok or frame_err). The parser recovers
//            from junk bytes, oversize lengths and stalled senders by itself.
// Ports    : sys_clk, sys_rst          clock, synchronous active-high reset
//            uart_rx_done/uart_rx_data byte-ready level and byte from receiver
//            pl_valid/pl_data/pl_index payload byte strobe, data, position
//            frame_cmd/frame_len       command and length of current/last frame
//            frame_ok/frame_err        one-cycle verdict strobes
//            err_code                  01 checksum, 10 length, 11 timeout
//            busy                      high whenever a frame is in progress
//            ok_cnt/err_cnt            wrapping good/bad frame counters
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_parser #(
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 1_000_000,
    parameter logic [7:0]  HDR0         = 8'hAA,
    parameter logic [7:0]  HDR1         = 8'h55
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rx_done,
    input  logic [7:0]  uart_rx_data,
    output logic        pl_valid,
    output logic [7:0]  pl_data,
    output logic [7:0]  pl_index,
    output logic [7:0]  frame_cmd,
    output logic [7:0]  frame_len,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [7:0]  c_MAX_LEN  = 8'(MAX_LEN);
    localparam logic [23:0] c_TO_LAST  = 24'(TIMEOUT_CLKS - 1);
    localparam logic [1:0]  c_ERR_CSUM = 2'b01;
    localparam logic [1:0]  c_ERR_LEN  = 2'b10;
    localparam logic [1:0]  c_ERR_TO   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR1    = 3'd1,
        ST_CMD     = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CSUM    = 3'd5
    } state_t;

    state_t      r_state_q,     w_state_d;
    logic        r_done_q;
    logic [7:0]  r_sum_q,       w_sum_d;
    logic [7:0]  r_idx_q,       w_idx_d;
    logic [23:0] r_to_cnt_q,    w_to_cnt_d;
    logic        r_pl_valid_q,  w_pl_valid_d;
    logic [7:0]  r_pl_data_q,   w_pl_data_d;
    logic [7:0]  r_pl_index_q,  w_pl_index_d;
    logic [7:0]  r_frame_cmd_q, w_frame_cmd_d;
    logic [7:0]  r_frame_len_q, w_frame_len_d;
    logic        r_frame_ok_q,  w_frame_ok_d;
    logic        r_frame_err_q, w_frame_err_d;
    logic [1:0]  r_err_code_q,  w_err_code_d;
    logic        r_busy_q,      w_busy_d;
    logic [15:0] r_ok_cnt_q,    w_ok_cnt_d;
    logic [15:0] r_err_cnt_q,   w_err_cnt_d;

    // Rising edge of the receiver's level: a held level is taken only once.
    logic w_byte_stb;
    logic w_timeout;
    assign w_byte_stb = uart_rx_done & ~r_done_q;
    // An arriving byte beats an expiring timer in the same cycle.
    assign w_timeout  = (r_state_q != ST_IDLE) && !w_byte_stb && (r_to_cnt_q == c_TO_LAST);

    always_comb begin
        w_state_d     = r_state_q;
        w_sum_d       = r_sum_q;
        w_idx_d       = r_idx_q;
        w_pl_valid_d  = 1'b0;
        w_pl_data_d   = r_pl_data_q;
        w_pl_index_d  = r_pl_index_q;
        w_frame_cmd_d = r_frame_cmd_q;
        w_frame_len_d = r_frame_len_q;
        w_frame_ok_d  = 1'b0;
        w_frame_err_d = 1'b0;
        w_err_code_d  = r_err_code_q;
        w_ok_cnt_d    = r_ok_cnt_q;
        w_err_cnt_d   = r_err_cnt_q;

        if (r_state_q == ST_IDLE || w_byte_stb || w_timeout) begin
            w_to_cnt_d = 24'd0;
        end else begin
            w_to_cnt_d = r_to_cnt_q + 24'd1;
        end

        if (w_timeout) begin
            w_state_d     = ST_IDLE;
            w_frame_err_d = 1'b1;
            w_err_code_d  = c_ERR_TO;
            w_err_cnt_d   = r_err_cnt_q + 16'd1;
        end else if (w_byte_stb) begin
            unique case (r_state_q)
                ST_IDLE: begin
                    if (uart_rx_data == HDR0) begin
                        w_state_d = ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    // A repeated HDR0 is treated as the start of a new header.
                    if (uart_rx_data == HDR1) begin
                        w_state_d = ST_CMD;
                    end else if (uart_rx_data != HDR0) begin
                        w_state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    w_frame_cmd_d = uart_rx_data;
                    w_sum_d       = uart_rx_data;
                    w_state_d     = ST_LEN;
                end
                ST_LEN: begin
                    w_frame_len_d = uart_rx_data;
                    w_sum_d       = r_sum_q + uart_rx_data;
                    if (uart_rx_data > c_MAX_LEN) begin
                        w_state_d     = ST_IDLE;
                        w_frame_err_d = 1'b1;
                        w_err_code_d  = c_ERR_LEN;
                        w_err_cnt_d   = r_err_cnt_q + 16'd1;
                    end else if (uart_rx_data == 8'd0) begin
                        w_state_d = ST_CSUM;
                    end else begin
                        w_idx_d   = 8'd0;
                        w_state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    w_pl_valid_d = 1'b1;
                    w_pl_data_d  = uart_rx_data;
                    w_pl_index_d = r_idx_q;
                    w_sum_d      = r_sum_q + uart_rx_data;
                    w_idx_d      = r_idx_q + 8'd1;
                    if (r_idx_q == r_frame_len_q - 8'd1) begin
                        w_state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    w_state_d = ST_IDLE;
                    if (uart_rx_data == r_sum_q) begin
                        w_frame_ok_d = 1'b1;
                        w_ok_cnt_d   = r_ok_cnt_q + 16'd1;
                    end else begin
                        w_frame_err_d = 1'b1;
                        w_err_code_d  = c_ERR_CSUM;
                        w_err_cnt_d   = r_err_cnt_q + 16'd1;
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                end
            endcase
        end

        // Registered so busy falls in the same cycle as the verdict strobe.
        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state_q     <= ST_IDLE;
            r_done_q      <= 1'b0;
            r_sum_q       <= 8'd0;
            r_idx_q       <= 8'd0;
            r_to_cnt_q    <= 24'd0;
            r_pl_valid_q  <= 1'b0;
            r_pl_data_q   <= 8'd0;
            r_pl_index_q  <= 8'd0;
            r_frame_cmd_q <= 8'd0;
            r_frame_len_q <= 8'd0;
            r_frame_ok_q  <= 1'b0;
            r_frame_err_q <= 1'b0;
            r_err_code_q  <= 2'b00;
            r_busy_q      <= 1'b0;
            r_ok_cnt_q    <= 16'd0;
            r_err_cnt_q   <= 16'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_done_q      <= uart_rx_done;
            r_sum_q       <= w_sum_d;
            r_idx_q       <= w_idx_d;
            r_to_cnt_q    <= w_to_cnt_d;
            r_pl_valid_q  <= w_pl_valid_d;
            r_pl_data_q   <= w_pl_data_d;
            r_pl_index_q  <= w_pl_index_d;
            r_frame_cmd_q <= w_frame_cmd_d;
            r_frame_len_q <= w_frame_len_d;
            r_frame_ok_q  <= w_frame_ok_d;
            r_frame_err_q <= w_frame_err_d;
            r_err_code_q  <= w_err_code_d;
            r_busy_q      <= w_busy_d;
            r_ok_cnt_q    <= w_ok_cnt_d;
            r_err_cnt_q   <= w_err_cnt_d;
        end
    end

    assign pl_valid  = r_pl_valid_q;
    assign pl_data   = r_pl_data_q;
    assign pl_index  = r_pl_index_q;
    assign frame_cmd = r_frame_cmd_q;
    assign frame_len = r_frame_len_q;
    assign frame_ok  = r_frame_ok_q;
    assign frame_err = r_frame_err_q;
    assign err_code  = r_err_code_q;
    assign busy      = r_busy_q;
    assign ok_cnt    = r_ok_cnt_q;
    assign err_cnt   = r_err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_parser
// Purpose  : Self-checking bench for uart_frame_parser. A frame-level model
//            (header tracking plus a queue of frame body bytes) predicts every
//            output each cycle; literal expectations pin key results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_parser;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned TO      = 100;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        uart_rx_done = 1'b0;
    logic [7:0]  uart_rx_data = 8'h00;
    logic        pl_valid;
    logic [7:0]  pl_data;
    logic [7:0]  pl_index;
    logic [7:0]  frame_cmd;
    logic [7:0]  frame_len;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;

    uart_frame_parser #(
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TO),
        .HDR0         (8'hAA),
        .HDR1         (8'h55)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .uart_rx_done (uart_rx_done),
        .uart_rx_data (uart_rx_data),
        .pl_valid     (pl_valid),
        .pl_data      (pl_data),
        .pl_index     (pl_index),
        .frame_cmd    (frame_cmd),
        .frame_len    (frame_len),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .busy         (busy),
        .ok_cnt       (ok_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- expected outputs ----------------
    logic        e_pl_valid, e_ok, e_err, e_busy;
    logic [7:0]  e_pl_data, e_pl_index, e_cmd, e_len;
    logic [1:0]  e_code;
    logic [15:0] e_okc, e_errc;

    // ---------------- frame-level model state ----------------
    bit          m_hdr;       // first header byte seen
    bit          m_in_frame;  // full header seen, collecting body bytes
    logic [7:0]  m_body[$];   // CMD, LEN, payload..., CSUM
    int          m_sil;       // cycles without an accepted byte while busy
    bit          m_prev_done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int last_acc = 0;
    int err_cyc = 0;
    int n_pl, n_ok, n_err;
    logic [7:0] pl_seen[$];
    logic [7:0] idx_seen[$];
    logic [7:0] seq[$];

    function automatic void model_reset();
        e_pl_valid = 0; e_ok = 0; e_err = 0; e_busy = 0;
        e_pl_data = 0; e_pl_index = 0; e_cmd = 0; e_len = 0;
        e_code = 0; e_okc = 0; e_errc = 0;
        m_hdr = 0; m_in_frame = 0; m_body.delete(); m_sil = 0; m_prev_done = 0;
    endfunction

    function automatic void model_end();
        m_hdr = 0; m_in_frame = 0; m_body.delete(); e_busy = 0;
    endfunction

    function automatic void model_err(input logic [1:0] c);
        e_err = 1; e_code = c; e_errc = e_errc + 16'd1;
        model_end();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int n;
        int l;
        logic [7:0] s;
        if (!m_in_frame) begin
            if (!m_hdr) begin
                if (b == 8'hAA) begin m_hdr = 1; e_busy = 1; end
            end else if (b == 8'h55) begin
                m_in_frame = 1; m_body.delete();
            end else if (b != 8'hAA) begin
                model_end();
            end
        end else begin
            m_body.push_back(b);
            n = m_body.size();
            l = int'(e_len);
            if (n == 1) e_cmd = b;
            if (n == 2) begin
                e_len = b;
                l = int'(b);
                if (l > int'(MAX_LEN)) begin
                    model_err(2'b10);
                    return;
                end
            end
            if (n >= 3 && n <= l + 2) begin
                e_pl_valid = 1; e_pl_data = b; e_pl_index = 8'(n - 3);
            end else if (n >= 3 && n == l + 3) begin
                s = 8'd0;
                for (int i = 0; i < n - 1; i++) s = s + m_body[i];
                if (s == b) begin
                    e_ok = 1; e_okc = e_okc + 16'd1; model_end();
                end else begin
                    model_err(2'b01);
                end
            end
        end
    endfunction

    // Advance one clock; inputs set before the call are what the DUT sampled.
    task automatic tick();
        bit acc;
        @(posedge sys_clk);
        cyc++;
        #1;
        e_pl_valid = 0; e_ok = 0; e_err = 0;
        if (sys_rst) begin
            model_reset();
        end else begin
            acc = uart_rx_done && !m_prev_done;
            m_prev_done = uart_rx_done;
            if (acc) begin
                m_sil = 0;
                last_acc = cyc;
                model_byte(uart_rx_data);
            end else if (m_hdr || m_in_frame) begin
                m_sil++;
                if (m_sil == int'(TO)) model_err(2'b11);
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        uart_rx_done = 1'b1; uart_rx_data = b;
        tick();
        uart_rx_done = 1'b0;
        tick();
    endtask

    task automatic send_seq();
        foreach (seq[i]) send(seq[i]);
        tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void clear_mon();
        n_pl = 0; n_ok = 0; n_err = 0; pl_seen.delete(); idx_seen.delete();
    endfunction

    // Every-cycle compare against the model, plus strobe monitors.
    always @(negedge sys_clk) begin
        if (chk_en) begin
            checks++;
            if ({pl_valid, pl_data, pl_index, frame_cmd, frame_len, frame_ok, frame_err,
                 err_code, busy, ok_cnt, err_cnt} !==
                {e_pl_valid, e_pl_data, e_pl_index, e_cmd, e_len, e_ok, e_err,
                 e_code, e_busy, e_okc, e_errc}) begin
                errors++;
                $display("FAIL model cyc %0d: got v=%b d=%h i=%h cmd=%h len=%h ok=%b err=%b code=%b busy=%b okc=%0d errc=%0d expected v=%b d=%h i=%h cmd=%h len=%h ok=%b err=%b code=%b busy=%b okc=%0d errc=%0d",
                         cyc, pl_valid, pl_data, pl_index, frame_cmd, frame_len, frame_ok, frame_err,
                         err_code, busy, ok_cnt, err_cnt,
                         e_pl_valid, e_pl_data, e_pl_index, e_cmd, e_len, e_ok, e_err,
                         e_code, e_busy, e_okc, e_errc);
            end
            if (pl_valid === 1'b1) begin n_pl++; pl_seen.push_back(pl_data); idx_seen.push_back(pl_index); end
            if (frame_ok === 1'b1) n_ok++;
            if (frame_err === 1'b1) begin n_err++; err_cyc = cyc; end
        end
    end

    initial begin
        model_reset();
        clear_mon();
        sys_rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        sys_rst = 1'b0;
        tick();
        check("reset_outputs", {9'd0, busy, frame_ok, frame_err, err_code, frame_cmd, frame_len, ok_cnt[3:0], err_cnt[3:0]}, 32'd0);

        // Good frame
        clear_mon();
        seq = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        send_seq();
        check("good_npl", n_pl, 2);
        check("good_pl0", (pl_seen.size() > 0) ? {24'd0, pl_seen[0]} : 32'hDEAD, 32'h10);
        check("good_pl1", (pl_seen.size() > 1) ? {16'd0, idx_seen[1], pl_seen[1]} : 32'hDEAD, 32'h0120);
        check("good_nok", n_ok, 1);
        check("good_cmd_len", {16'd0, frame_cmd, frame_len}, 32'h0102);
        check("good_okcnt", ok_cnt, 1);

        // Bad checksum
        clear_mon();
        seq = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
        send_seq();
        check("badcs_npl", n_pl, 2);
        check("badcs_verdict", {n_ok[7:0], n_err[7:0]}, 32'h0001);
        check("badcs_code", err_code, 2'b01);
        check("badcs_errcnt", err_cnt, 1);

        // Oversize length then zero length
        clear_mon();
        seq = '{8'hAA, 8'h55, 8'h07, 8'h11};
        send_seq();
        check("len_err", {n_err[7:0], 6'd0, err_code}, 32'h0102);
        check("len_busy", busy, 0);
        clear_mon();
        seq = '{8'hAA, 8'h55, 8'h07, 8'h00, 8'h07};
        send_seq();
        check("zero_ok", {n_ok[7:0], n_pl[7:0]}, 32'h0100);
        check("zero_cnts", {ok_cnt, err_cnt}, {16'd2, 16'd2});

        // Payload at exactly MAX_LEN
        clear_mon();
        seq = '{8'hAA, 8'h55, 8'h02, 8'h10};
        for (int i = 1; i <= 16; i++) seq.push_back(8'(i));
        seq.push_back(8'h9A);
        send_seq();
        check("max_npl", n_pl, 16);
        check("max_last_idx", (idx_seen.size() == 16) ? {24'd0, idx_seen[15]} : 32'hDEAD, 32'd15);
        check("max_ok", n_ok, 1);

        // Junk and header resync
        clear_mon();
        seq = '{8'h3C, 8'hAA, 8'hAA, 8'h55, 8'h05, 8'h00, 8'h05};
        send_seq();
        check("resync_ok", {n_ok[7:0], n_err[7:0]}, 32'h0100);
        check("resync_errcnt", err_cnt, 2);

        // Timeout after CMD
        clear_mon();
        seq = '{8'hAA, 8'h55, 8'h01};
        foreach (seq[i]) send(seq[i]);
        for (int i = 0; i < 120; i++) tick();
        check("to_count", n_err, 1);
        check("to_latency", err_cyc - last_acc, TO);
        check("to_code", err_code, 2'b11);
        check("to_busy", busy, 0);

        // Long-held level accepted once (HDR1 state then times out exactly once)
        clear_mon();
        uart_rx_done = 1'b1; uart_rx_data = 8'hAA;
        for (int i = 0; i < 2604; i++) tick();
        uart_rx_done = 1'b0;
        tick(); tick();
        check("held_once", n_err, 1);
        check("held_errcnt", err_cnt, 4);
        send(8'h55);
        tick();
        check("held_idle", busy, 0);

        // Reset in the middle of a payload
        clear_mon();
        seq = '{8'hAA, 8'h55, 8'h01, 8'h04, 8'h10, 8'h20};
        foreach (seq[i]) send(seq[i]);
        sys_rst = 1'b1;
        tick();
        check("rst_zero", {pl_valid, pl_data, pl_index, frame_cmd, frame_len[6:0]}, 32'd0);
        check("rst_zero2", {frame_ok, frame_err, err_code, busy, ok_cnt, err_cnt[10:0]}, 32'd0);
        sys_rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rst_noverdict", {n_ok[7:0], n_err[7:0]}, 32'd0);
        seq = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        send_seq();
        check("rst_after_ok", ok_cnt, 1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level framing controller that sits directly behind the UART receiver. It consumes the receiver's `uart_rx_done`/`uart_rx_data` outputs and sequences them through a fixed command-frame format: two header bytes, a command, a length, a payload, and a checksum. It streams payload bytes downstream as they arrive, then issues exactly one verdict per frame (ok or error). It also recovers from line noise, oversize lengths and stalled senders without external help.

## Interface
Parameters:
- `MAX_LEN`, 16: largest legal payload length in bytes (1..255).
- `TIMEOUT_CLKS`, 1_000_000: inter-byte timeout in `sys_clk` cycles (20 ms at 50 MHz); counter width 24 bits.
- `HDR0`, 8'hAA: first header byte.
- `HDR1`, 8'h55: second header byte.

Ports:
- `sys_clk`  in  1  system clock (50 MHz).
- `sys_rst`  in  1  reset; one clock, synchronous, active-high. Every register clears on `sys_clk` rising edge while high.
- `uart_rx_done`  in  1  byte-ready level from the receiver. May stay high for many cycles per byte.
- `uart_rx_data`  in  8  received byte. Valid whenever `uart_rx_done` is high.
- `pl_valid`  out  1  one-cycle strobe, payload byte available.
- `pl_data`  out  8  payload byte, qualified by `pl_valid`.
- `pl_index`  out  8  0-based position of `pl_data` within the payload.
- `frame_cmd`  out  8  command byte of the current/last frame. Held until the next CMD byte.
- `frame_len`  out  8  length byte of the current/last frame. Held until the next LEN byte.
- `frame_ok`  out  1  one-cycle strobe, checksum matched.
- `frame_err`  out  1  one-cycle strobe, frame aborted.
- `err_code`  out  2  reason, valid with `frame_err`: 2'b01 checksum, 2'b10 length, 2'b11 timeout. Held until the next error.
- `busy`  out  1  high in every state except IDLE.
- `ok_cnt`  out  16  count of good frames, wraps at 16'hFFFF→0.
- `err_cnt`  out  16  count of error frames, wraps.

## Operation
- Byte accept: register `uart_rx_done` into `done_d`. `byte_stb = uart_rx_done & ~done_d`. A byte is accepted only on `byte_stb`, one per rising edge of `uart_rx_done`. A long-held level is never re-accepted.
- FSM states: IDLE, HDR1, CMD, LEN, PAYLOAD, CSUM. All transitions below occur on `byte_stb` unless noted.
- IDLE: byte==HDR0 → HDR1; otherwise stay in IDLE. No error for junk bytes.
- HDR1: byte==HDR1 → CMD. byte==HDR0 → stay in HDR1 (resync). Any other byte → IDLE, no error.
- CMD: latch `frame_cmd`; `sum <= byte` → LEN.
- LEN: latch `frame_len`; `sum <= sum + byte` (8-bit, mod 256).
  - byte > MAX_LEN → `frame_err`, `err_code`=10 → IDLE.
  - byte == 0 → CSUM.
  - otherwise clear `idx` → PAYLOAD.
- PAYLOAD: pulse `pl_valid` with `pl_data`=byte and `pl_index`=idx; `sum += byte`; `idx++`. When idx == `frame_len`−1 → CSUM.
- CSUM: byte==sum → `frame_ok`, `ok_cnt++`. Otherwise → `frame_err`, `err_code`=01. Either way → IDLE.
- Timeout: `to_cnt` clears on every `byte_stb` and in IDLE. It increments each cycle in any other state. On `to_cnt == TIMEOUT_CLKS−1` → `frame_err`, `err_code`=11 → IDLE. If `byte_stb` occurs in that same cycle, the byte wins: it is processed and the counter clears.
- Every `frame_err` increments `err_cnt`. `frame_ok` and `frame_err` are mutually exclusive and at most one fires per frame.
- Reset mid-frame: state → IDLE, all strobes 0, counters 0, `frame_cmd`/`frame_len`/`err_code`/`pl_*` → 0. A partial frame yields no verdict.

## Timing
- Reset values of all outputs: 0.
- All outputs are registered. `pl_valid`, `frame_ok` and `frame_err` assert in the cycle after the `sys_clk` edge at which `byte_stb` is high (1-cycle latency from the `uart_rx_done` rise seen by the block), and last exactly 1 cycle.
- `frame_cmd`/`frame_len` update with the same 1-cycle latency.
- `busy` goes high the cycle after the HDR0 byte is accepted, and low in the same cycle as the verdict strobe.
- Back-to-back bytes: one per `uart_rx_done` rise. Minimum spacing 2 cycles (high then low) must be supported.

## Test plan
- Good frame: AA 55 01 02 10 20 33 → `pl_valid` twice (10 @ idx0, 20 @ idx1); `frame_ok` once; `frame_cmd`=01, `frame_len`=02; `ok_cnt`=1.
- Bad checksum: AA 55 01 02 10 20 34 → two payload strobes, then `frame_err`, `err_code`=01, `err_cnt`=1, no `frame_ok`.
- Length/zero: AA 55 07 11 (MAX_LEN=16) → `frame_err` code 10 right after the 11 byte. Then AA 55 07 00 07 → `frame_ok` with no `pl_valid`.
- Resync/junk: 3C AA AA 55 05 00 05 → junk ignored, `frame_ok`, `err_cnt` unchanged.
- Timeout: AA 55 01, then silence for TIMEOUT_CLKS cycles (TIMEOUT_CLKS=100 in sim) → `frame_err` code 11 exactly 100 cycles after the last accept; `busy` drops.
- Held level / reset: hold `uart_rx_done` high for 2604 cycles with AA → accepted once only. Assert `sys_rst` mid-PAYLOAD → all outputs 0 next cycle, no verdict strobe.
